// File: rtl/pcie_tx_cpl_rr_arb.sv
// Packet-granular round-robin merge of NUM_PORTS completion streams onto one PCIe TX AXI-S port.
// One registered output stage at full rate; a granted port owns the output until its tlast is taken.
module pcie_tx_cpl_rr_arb #(
   parameter int NUM_PORTS   = 4,
   parameter int DATA_W      = 512,
   parameter int USER_W      = 10,
   parameter int STALL_LIMIT = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          i_tvalid,
   output logic [NUM_PORTS-1:0]          o_tready_in,
   input  logic [NUM_PORTS*DATA_W-1:0]   i_tdata,
   input  logic [NUM_PORTS*DATA_W/8-1:0] i_tkeep,
   input  logic [NUM_PORTS-1:0]          i_tlast,
   input  logic [NUM_PORTS*USER_W-1:0]   i_tuser,
   output logic                          o_tvalid,
   input  logic                          i_tready,
   output logic [DATA_W-1:0]             o_tdata,
   output logic [DATA_W/8-1:0]           o_tkeep,
   output logic                          o_tlast,
   output logic [USER_W-1:0]             o_tuser,
   output logic [$clog2(NUM_PORTS)-1:0]  o_grant,
   output logic                          o_err_stall
);

   localparam int GW = $clog2(NUM_PORTS);
   localparam int KW = DATA_W / 8;
   localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [CW-1:0] STALL_MAX = CW'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q;
   logic [GW-1:0]    rr_ptr_q;
   logic [GW-1:0]    grant_q;
   logic [CW-1:0]    stall_cnt_q;
   logic             err_q;
   logic             tvalid_q;
   logic [DATA_W-1:0] tdata_q;
   logic [KW-1:0]    tkeep_q;
   logic             tlast_q;
   logic [USER_W-1:0] tuser_q;

   logic [GW-1:0]    winner;
   logic             win_vld;
   logic [GW-1:0]    idx;
   logic [GW-1:0]    sel;
   logic             sel_en;
   logic             load_en;
   logic             acc;

   // Search rr_ptr+1 .. rr_ptr+NUM_PORTS; iterating backwards lets the nearest valid port win.
   always_comb begin
      winner  = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = GW'((int'(rr_ptr_q) + i) % NUM_PORTS);
         if (i_tvalid[idx]) begin
            winner  = idx;
            win_vld = 1'b1;
         end
      end
   end

   assign load_en = ~tvalid_q | i_tready;
   assign sel     = (state_q == LOCKED) ? grant_q : winner;
   assign sel_en  = (state_q == LOCKED) | win_vld;
   assign acc     = load_en & sel_en & i_tvalid[sel];

   always_comb begin
      o_tready_in = '0;
      if (sel_en) o_tready_in[sel] = load_en;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= GW'(NUM_PORTS - 1);
         grant_q     <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= '0;
      end else begin
         if (acc) begin
            tvalid_q <= 1'b1;
            tdata_q  <= i_tdata[sel*DATA_W +: DATA_W];
            tkeep_q  <= i_tkeep[sel*KW +: KW];
            tlast_q  <= i_tlast[sel];
            tuser_q  <= i_tuser[sel*USER_W +: USER_W];
            grant_q  <= sel;
            if (i_tlast[sel]) begin
               state_q  <= IDLE;
               rr_ptr_q <= sel;
            end else begin
               state_q  <= LOCKED;
            end
         end else if (i_tready) begin
            tvalid_q <= 1'b0;
         end

         // Only a granted source going quiet mid-packet counts; sink backpressure does not.
         if (state_q != LOCKED || acc) begin
            stall_cnt_q <= '0;
         end else if (!i_tvalid[grant_q]) begin
            if (STALL_LIMIT > 0 && stall_cnt_q == STALL_MAX) err_q <= 1'b1;
            if (stall_cnt_q != STALL_MAX) stall_cnt_q <= stall_cnt_q + CW'(1);
         end
      end
   end

   assign o_tvalid    = tvalid_q;
   assign o_tdata     = tdata_q;
   assign o_tkeep     = tkeep_q;
   assign o_tlast     = tlast_q;
   assign o_tuser     = tuser_q;
   assign o_grant     = grant_q;
   assign o_err_stall = err_q;

endmodule

// File: tb/tb_pcie_tx_cpl_rr_arb.sv
// Bench for pcie_tx_cpl_rr_arb: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin reference model.
module tb_pcie_tx_cpl_rr_arb;

   localparam int NP  = 4;
   localparam int DW  = 64;
   localparam int KW  = DW / 8;
   localparam int UW  = 10;
   localparam int LIM = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
      logic          f;
      logic [1:0]    p;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NP-1:0]     i_tvalid = '0;
   logic [NP-1:0]     o_tready_in;
   logic [NP*DW-1:0]  i_tdata = '0;
   logic [NP*KW-1:0]  i_tkeep = '0;
   logic [NP-1:0]     i_tlast = '0;
   logic [NP*UW-1:0]  i_tuser = '0;
   logic              o_tvalid;
   logic              i_tready = 1'b0;
   logic [DW-1:0]     o_tdata;
   logic [KW-1:0]     o_tkeep;
   logic              o_tlast;
   logic [UW-1:0]     o_tuser;
   logic [1:0]        o_grant;
   logic              o_err_stall;

   int tests = 0;
   int fails = 0;
   int mptr  = NP - 1;
   beat_t srcq [NP][$];
   beat_t expq [$];
   beat_t inq  [$];

   pcie_tx_cpl_rr_arb #(
      .NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .STALL_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_tvalid(i_tvalid), .o_tready_in(o_tready_in),
      .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tuser(i_tuser),
      .o_tvalid(o_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_tuser(o_tuser),
      .o_grant(o_grant), .o_err_stall(o_err_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drv(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic [UW-1:0] u, input logic l);
      i_tvalid[p]          = 1'b1;
      i_tdata[p*DW +: DW]  = d;
      i_tkeep[p*KW +: KW]  = k;
      i_tuser[p*UW +: UW]  = u;
      i_tlast[p]           = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      i_tvalid = '0;
      i_tready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_tvalid", 64'(o_tvalid), 64'd0);
      chk("rst_tlast", 64'(o_tlast), 64'd0);
      chk("rst_err", 64'(o_err_stall), 64'd0);
      chk("rst_tdata", 64'(o_tdata), 64'd0);
      chk("rst_tkeep", 64'(o_tkeep), 64'd0);
      chk("rst_tuser", 64'(o_tuser), 64'd0);
      chk("rst_grant", 64'(o_grant), 64'd0);
      chk("rst_ready", 64'(o_tready_in), 64'd0);
      rst_n = 1'b1;
      mptr  = NP - 1;
   endtask

   task automatic add_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = {$urandom, $urandom};
         b.k = KW'($urandom);
         b.u = UW'($urandom);
         b.l = (i == len - 1);
         b.f = (i == 0);
         b.p = 2'(p);
         srcq[p].push_back(b);
      end
   endtask

   // Reference: whole packets leave in round-robin order among ports that still hold one,
   // starting after the port whose packet finished last.
   task automatic build_exp();
      beat_t mq [NP][$];
      beat_t b;
      int    nxt;
      bit    any;
      for (int p = 0; p < NP; p++) mq[p] = srcq[p];
      do begin
         any = 1'b0;
         nxt = 0;
         for (int i = 1; i <= NP; i++) begin
            if (!any && mq[(mptr + i) % NP].size() > 0) begin
               any = 1'b1;
               nxt = (mptr + i) % NP;
            end
         end
         if (any) begin
            do begin
               b = mq[nxt].pop_front();
               expq.push_back(b);
               inq.push_back(b);
            end while (!b.l);
            mptr = nxt;
         end
      end while (any);
   endtask

   task automatic run(input int rdy_pct, input int gap_pct, input int budget,
                      output int nbeats, output int span);
      beat_t b;
      int    first, lastc, cyc;
      int    gapc [NP];
      bit    v;
      build_exp();
      nbeats = 0;
      first  = -1;
      lastc  = 0;
      for (int p = 0; p < NP; p++) gapc[p] = 0;
      for (cyc = 0; cyc < budget && (expq.size() > 0 || inq.size() > 0); cyc++) begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            v = 1'b0;
            if (srcq[p].size() > 0) begin
               b = srcq[p][0];
               v = 1'b1;
               if (!b.f && gapc[p] < 3 && $urandom_range(99) < gap_pct) v = 1'b0;
               i_tdata[p*DW +: DW] = b.d;
               i_tkeep[p*KW +: KW] = b.k;
               i_tuser[p*UW +: UW] = b.u;
               i_tlast[p]          = b.l;
            end
            gapc[p]     = v ? 0 : gapc[p] + 1;
            i_tvalid[p] = v;
         end
         i_tready = ($urandom_range(99) < rdy_pct);
         #1;
         chk("ready_onehot0", 64'($countones(o_tready_in) <= 1), 64'd1);
         if (o_tvalid && i_tready) begin
            chk("out_expected", 64'(expq.size() > 0), 64'd1);
            if (expq.size() > 0) begin
               b = expq.pop_front();
               chk("out_tdata", 64'(o_tdata), 64'(b.d));
               chk("out_tkeep", 64'(o_tkeep), 64'(b.k));
               chk("out_tuser", 64'(o_tuser), 64'(b.u));
               chk("out_tlast", 64'(o_tlast), 64'(b.l));
               chk("out_grant", 64'(o_grant), 64'(b.p));
               nbeats++;
               if (first < 0) first = cyc;
               lastc = cyc;
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (i_tvalid[p] && o_tready_in[p]) begin
               chk("in_expected", 64'(inq.size() > 0), 64'd1);
               if (inq.size() > 0) begin
                  b = inq.pop_front();
                  chk("in_port", 64'(p), 64'(b.p));
               end
               void'(srcq[p].pop_front());
            end
         end
      end
      @(negedge clk);
      i_tvalid = '0;
      chk("drain_out", 64'(expq.size()), 64'd0);
      chk("drain_in", 64'(inq.size()), 64'd0);
      expq.delete();
      inq.delete();
      for (int p = 0; p < NP; p++) srcq[p].delete();
      span = (first < 0) ? 0 : lastc - first + 1;
   endtask

   int nb, sp;

   initial begin
      // Reset state
      do_reset();

      // T1: single-beat completion from port 0
      @(negedge clk);
      drv(0, 64'hA5A5_A5A5_A5A5_A5A5, 8'h3C, 10'h2B5, 1'b1);
      i_tready = 1'b1;
      #1;
      chk("t1_ready", 64'(o_tready_in), 64'b0001);
      chk("t1_vld_before", 64'(o_tvalid), 64'd0);
      @(negedge clk);
      i_tvalid = '0;
      #1;
      chk("t1_vld", 64'(o_tvalid), 64'd1);
      chk("t1_tdata", 64'(o_tdata), 64'hA5A5_A5A5_A5A5_A5A5);
      chk("t1_tkeep", 64'(o_tkeep), 64'h3C);
      chk("t1_tuser", 64'(o_tuser), 64'h2B5);
      chk("t1_tlast", 64'(o_tlast), 64'd1);
      chk("t1_grant", 64'(o_grant), 64'd0);
      @(negedge clk);
      #1;
      chk("t1_vld_drop", 64'(o_tvalid), 64'd0);

      // T2: all ports continuously valid with 1-beat packets -> 0,1,2,3,... at full rate
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < NP; p++) add_pkt(p, 1);
      run(100, 0, 200, nb, sp);
      chk("t2_beats", 64'(nb), 64'd12);
      chk("t2_span", 64'(sp), 64'd12);

      // T3: port1 3-beat packet must not be interleaved with waiting port2
      do_reset();
      add_pkt(1, 3);
      add_pkt(2, 1);
      run(100, 0, 200, nb, sp);
      chk("t3_beats", 64'(nb), 64'd4);
      chk("t3_span", 64'(sp), 64'd4);

      // T4: sink backpressure for 5 cycles holds the slot and blocks all sources
      do_reset();
      @(negedge clk);
      drv(0, 64'h1111_2222_3333_4444, 8'hFF, 10'h001, 1'b0);
      i_tready = 1'b1;
      @(negedge clk);
      drv(0, 64'h5555_6666_7777_8888, 8'h0F, 10'h002, 1'b1);
      i_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_vld", 64'(o_tvalid), 64'd1);
         chk("t4_hold_dat", 64'(o_tdata), 64'h1111_2222_3333_4444);
         chk("t4_ready_low", 64'(o_tready_in), 64'd0);
         @(negedge clk);
      end
      i_tready = 1'b1;
      #1;
      chk("t4_release_ready", 64'(o_tready_in), 64'b0001);
      chk("t4_release_dat", 64'(o_tdata), 64'h1111_2222_3333_4444);
      @(negedge clk);
      i_tvalid = '0;
      #1;
      chk("t4_second_dat", 64'(o_tdata), 64'h5555_6666_7777_8888);
      chk("t4_second_last", 64'(o_tlast), 64'd1);
      chk("t4_second_vld", 64'(o_tvalid), 64'd1);
      @(negedge clk);
      #1;
      chk("t4_empty", 64'(o_tvalid), 64'd0);

      // T5: granted port idles mid-packet -> sticky stall flag after LIM idle cycles
      do_reset();
      @(negedge clk);
      drv(0, 64'hCAFE_0000_0000_0001, 8'hFF, 10'h010, 1'b0);
      i_tready = 1'b1;
      @(negedge clk);
      i_tvalid = '0;
      drv(3, 64'hCAFE_0000_0000_0003, 8'hF0, 10'h030, 1'b1);
      for (int i = 1; i <= LIM + 3; i++) begin
         #1;
         chk("t5_port3_blocked", 64'(o_tready_in[3]), 64'd0);
         chk("t5_err", 64'(o_err_stall), 64'(i > LIM));
         @(negedge clk);
      end
      drv(0, 64'hCAFE_0000_0000_0002, 8'h0F, 10'h020, 1'b1);
      #1;
      chk("t5_port0_resume", 64'(o_tready_in), 64'b0001);
      @(negedge clk);
      i_tvalid[0] = 1'b0;
      #1;
      chk("t5_port3_granted", 64'(o_tready_in), 64'b1000);
      chk("t5_tail_dat", 64'(o_tdata), 64'hCAFE_0000_0000_0002);
      @(negedge clk);
      i_tvalid = '0;
      #1;
      chk("t5_p3_dat", 64'(o_tdata), 64'hCAFE_0000_0000_0003);
      chk("t5_p3_grant", 64'(o_grant), 64'd3);
      chk("t5_err_sticky", 64'(o_err_stall), 64'd1);

      // T6: reset in the middle of a port2 packet, then port0 wins over port2
      @(negedge clk);
      drv(2, 64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, 10'h100, 1'b0);
      i_tready = 1'b1;
      @(negedge clk);
      drv(2, 64'hD1D1_D1D1_D1D1_D1D1, 8'hFF, 10'h101, 1'b0);
      do_reset();
      add_pkt(0, 1);
      add_pkt(2, 1);
      run(100, 0, 100, nb, sp);
      chk("t6_beats", 64'(nb), 64'd2);

      // Randomized traffic: packet lengths, source gaps and sink backpressure
      for (int r = 0; r < 8; r++) begin
         for (int p = 0; p < NP; p++)
            repeat ($urandom_range(3)) add_pkt(p, $urandom_range(1, 4));
         run($urandom_range(40, 100), 30, 3000, nb, sp);
      end
      chk("rand_no_stall", 64'(o_err_stall), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
